// File: rtl/ssd_capture.sv
// Receive-side decoder for a multiplexed four-digit seven-segment bus.
// Filters scan transitions, decodes stable patterns and rebuilds the digit registers.
module ssd_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] blank,
    output logic [3:0] invalid,
    output logic       update,
    output logic       frame_done
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [10:0]   sample_q, sample_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d;
    logic [3:0]    dig_q [4];
    logic [3:0]    dig_d [4];
    logic [3:0]    blank_q, blank_d;
    logic [3:0]    invalid_q, invalid_d;
    logic [3:0]    seen_q, seen_d;
    logic          update_q, update_d;
    logic          frame_q, frame_d;

    logic          an_ok;
    logic [1:0]    idx;
    logic [6:0]    abcdefg;
    logic [4:0]    dec;
    logic [3:0]    seen_next;

    // Returns {hit, value}; hit=0 for anything outside the hex glyph set.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = {1'b1, 4'h0};
            7'b1001111: decode = {1'b1, 4'h1};
            7'b0010010: decode = {1'b1, 4'h2};
            7'b0000110: decode = {1'b1, 4'h3};
            7'b1001100: decode = {1'b1, 4'h4};
            7'b0100100: decode = {1'b1, 4'h5};
            7'b0100000: decode = {1'b1, 4'h6};
            7'b0001111: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0000100: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b1100000: decode = {1'b1, 4'hB};
            7'b0110001: decode = {1'b1, 4'hC};
            7'b1000010: decode = {1'b1, 4'hD};
            7'b0110000: decode = {1'b1, 4'hE};
            7'b0111000: decode = {1'b1, 4'hF};
            default:    decode = 5'b0_0000;
        endcase
    endfunction

    // Run filter: a zero count marks the first sample after reset as a fresh run.
    always_comb begin
        sample_d = {an, seg};
        an_ok    = (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
        if (cnt_q == '0 || sample_d != sample_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // Only the transition into saturation arms a capture, so a held pair fires once.
        hit_d = an_ok && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        dig_d     = dig_q;
        blank_d   = blank_q;
        invalid_d = invalid_q;
        seen_d    = seen_q;
        update_d  = 1'b0;
        frame_d   = 1'b0;

        case (sample_q[10:7])
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        abcdefg   = {sample_q[0], sample_q[1], sample_q[2], sample_q[3],
                     sample_q[4], sample_q[5], sample_q[6]};
        dec       = decode(abcdefg);
        seen_next = seen_q | (4'b0001 << idx);

        if (hit_q) begin
            update_d = 1'b1;
            if (dec[4]) begin
                dig_d[idx]     = dec[3:0];
                blank_d[idx]   = 1'b0;
                invalid_d[idx] = 1'b0;
            end else if (abcdefg == 7'b1111111) begin
                blank_d[idx]   = 1'b1;
                invalid_d[idx] = 1'b0;
            end else begin
                blank_d[idx]   = 1'b0;
                invalid_d[idx] = 1'b1;
            end
            // The completing capture's own seen bit is dropped along with the rest.
            if (seen_next == 4'b1111) begin
                frame_d = 1'b1;
                seen_d  = 4'b0000;
            end else begin
                seen_d  = seen_next;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q  <= '0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            dig_q     <= '{default: 4'h0};
            blank_q   <= 4'b1111;
            invalid_q <= 4'b0000;
            seen_q    <= 4'b0000;
            update_q  <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            dig_q     <= dig_d;
            blank_q   <= blank_d;
            invalid_q <= invalid_d;
            seen_q    <= seen_d;
            update_q  <= update_d;
            frame_q   <= frame_d;
        end
    end

    assign digit0     = dig_q[0];
    assign digit1     = dig_q[1];
    assign digit2     = dig_q[2];
    assign digit3     = dig_q[3];
    assign blank      = blank_q;
    assign invalid    = invalid_q;
    assign update     = update_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Bench for ssd_capture: directed scenarios plus random bus traffic checked
// against a run-length reference model of the capture rules.
module tb_ssd_capture;

    localparam int S = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = 7'h7F;
    logic [3:0] an  = 4'hF;
    logic [3:0] digit0, digit1, digit2, digit3, blank, invalid;
    logic       update, frame_done;

    ssd_capture #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .blank(blank), .invalid(invalid), .update(update), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // abcdefg glyphs for 0..F
    logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          run_len;
    bit          have_prev;
    logic [10:0] prev_pair;
    bit          pend;
    logic [10:0] pend_pair;
    logic [3:0]  e_dig [4];
    logic [3:0]  e_blank, e_inv, e_seen;
    bit          e_upd, e_frame;
    int          skew = 0;
    int          n_upd = 0;
    int          n_frame = 0;

    function automatic logic [6:0] rev7(input logic [6:0] x);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = x[6-i];
        return r;
    endfunction

    function automatic int lookup(input logic [6:0] abc);
        for (int v = 0; v < 16; v++) if (tbl[v] == abc) return v;
        return -1;
    endfunction

    function automatic logic [6:0] enc(input int v);
        return rev7(tbl[v]);
    endfunction

    task automatic model_reset();
        run_len = 0; have_prev = 0; prev_pair = '0; pend = 0; pend_pair = '0;
        for (int k = 0; k < 4; k++) e_dig[k] = 4'h0;
        e_blank = 4'hF; e_inv = 4'h0; e_seen = 4'h0; e_upd = 0; e_frame = 0;
    endtask

    task automatic apply_capture(input logic [10:0] p);
        int i, v;
        logic [6:0] abc;
        i = 0;
        for (int k = 0; k < 4; k++) if (!p[7+k]) i = k;
        abc = rev7(p[6:0]);
        v = lookup(abc);
        if (v >= 0) begin
            e_dig[i] = 4'(v); e_blank[i] = 1'b0; e_inv[i] = 1'b0;
        end else if (abc == 7'h7F) begin
            e_blank[i] = 1'b1; e_inv[i] = 1'b0;
        end else begin
            e_blank[i] = 1'b0; e_inv[i] = 1'b1;
        end
        e_upd = 1;
        e_seen[i] = 1'b1;
        if (e_seen == 4'hF) begin
            e_frame = 1; e_seen = 4'h0;
        end
    endtask

    // One clock: drive the pair, advance the model across the edge, sample DUT pulses.
    task automatic step(input logic [3:0] a, input logic [6:0] s);
        an = a; seg = s;
        @(posedge clk);
        e_upd = 0; e_frame = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (pend) apply_capture(pend_pair);
            pend = 0;
            if (!have_prev || {a, s} != prev_pair) run_len = 1;
            else run_len++;
            have_prev = 1; prev_pair = {a, s};
            if (run_len == S && $countones(~a) == 1) begin
                pend = 1; pend_pair = {a, s};
            end
        end
        #1;
        if (update !== e_upd || frame_done !== e_frame) skew++;
        if (update === 1'b1) n_upd++;
        if (frame_done === 1'b1) n_frame++;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int k = 0; k < n; k++) step(a, s);
    endtask

    task automatic test_reset();
        rst = 1;
        for (int k = 0; k < 3; k++) step(4'($urandom), 7'($urandom));
        rst = 0;
        checks++;
        if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin
            errors++; $display("FAIL reset_digits got %h exp 0000", {digit3, digit2, digit1, digit0});
        end
        checks++;
        if (blank !== 4'b1111) begin errors++; $display("FAIL reset_blank got %b exp 1111", blank); end
        checks++;
        if (invalid !== 4'b0000) begin errors++; $display("FAIL reset_invalid got %b exp 0000", invalid); end
        checks++;
        if (update !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got %b%b exp 00", update, frame_done);
        end
    endtask

    task automatic test_single();
        int u0 = n_upd;
        hold(4'b1110, 7'b0010010, S);
        checks++;
        if (n_upd != u0 || digit0 !== 4'h0) begin
            errors++; $display("FAIL single_early got upd=%0d d0=%h exp upd=0 d0=0", n_upd - u0, digit0);
        end
        step(4'b1110, 7'b0010010);
        checks++;
        if (digit0 !== 4'h5 || blank[0] !== 1'b0 || update !== 1'b1) begin
            errors++; $display("FAIL single_capture got d0=%h b0=%b upd=%b exp d0=5 b0=0 upd=1", digit0, blank[0], update);
        end
        hold(4'b1110, 7'b0010010, 100);
        checks++;
        if (n_upd - u0 != 1) begin errors++; $display("FAIL single_once got %0d updates exp 1", n_upd - u0); end
    endtask

    task automatic test_glitch();
        int u0 = n_upd;
        hold(4'b1101, 7'b0001000, 15);
        step(4'b1101, 7'b1111110);
        hold(4'b1101, 7'b0001000, 16);
        checks++;
        if (n_upd != u0 || digit1 !== 4'h0) begin
            errors++; $display("FAIL glitch_filtered got upd=%0d d1=%h exp upd=0 d1=0", n_upd - u0, digit1);
        end
        step(4'b1101, 7'b0001000);
        checks++;
        if (digit1 !== 4'hA || update !== 1'b1) begin
            errors++; $display("FAIL glitch_capture got d1=%h upd=%b exp d1=a upd=1", digit1, update);
        end
    endtask

    task automatic test_blank_invalid();
        hold(4'b1011, 7'b1111111, S + 1);
        checks++;
        if (blank[2] !== 1'b1 || digit2 !== 4'h0 || invalid[2] !== 1'b0) begin
            errors++; $display("FAIL blank_cap got b2=%b d2=%h i2=%b exp b2=1 d2=0 i2=0", blank[2], digit2, invalid[2]);
        end
        hold(4'b0111, 7'b1111110, S + 1);
        checks++;
        if (invalid !== 4'b1000 || blank !== 4'b0100 || digit3 !== 4'h0) begin
            errors++; $display("FAIL invalid_cap got i=%b b=%b d3=%h exp i=1000 b=0100 d3=0", invalid, blank, digit3);
        end
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL first_frame got %b exp 1", frame_done); end
    endtask

    task automatic scan_frame(input int v0, input int v1, input int v2, input int v3);
        hold(4'b1110, enc(v0), 20);
        hold(4'b1101, enc(v1), 20);
        hold(4'b1011, enc(v2), 20);
        hold(4'b0111, enc(v3), 20);
    endtask

    task automatic test_loopback();
        int f0;
        rst = 1; step(4'hF, 7'h7F); rst = 0;
        for (int r = 0; r < 3; r++) begin
            f0 = n_frame;
            scan_frame(15, 0, 12, 3);
            checks++;
            if (n_frame - f0 != 1) begin errors++; $display("FAIL loop_frame%0d got %0d exp 1", r, n_frame - f0); end
            checks++;
            if ({digit3, digit2, digit1, digit0} !== 16'h3C0F || blank !== 4'h0 || invalid !== 4'h0) begin
                errors++; $display("FAIL loop_digits%0d got %h b=%b i=%b exp 3c0f b=0000 i=0000",
                                   r, {digit3, digit2, digit1, digit0}, blank, invalid);
            end
        end
        for (int r = 0; r < 4; r++) begin
            int v[4];
            for (int k = 0; k < 4; k++) v[k] = $urandom_range(0, 15);
            f0 = n_frame;
            scan_frame(v[0], v[1], v[2], v[3]);
            checks++;
            if (n_frame - f0 != 1 || {digit3, digit2, digit1, digit0} !== {e_dig[3], e_dig[2], e_dig[1], e_dig[0]}) begin
                errors++; $display("FAIL loop_rand%0d got %h frames=%0d exp %h frames=1", r,
                                   {digit3, digit2, digit1, digit0}, n_frame - f0, {e_dig[3], e_dig[2], e_dig[1], e_dig[0]});
            end
        end
    endtask

    task automatic test_illegal_and_reset();
        int u0 = n_upd;
        hold(4'b1111, enc(8), 50);
        hold(4'b1100, enc(8), 50);
        checks++;
        if (n_upd != u0) begin errors++; $display("FAIL illegal_an got %0d updates exp 0", n_upd - u0); end
        hold(4'b1011, enc(6), 10);
        rst = 1; step(4'b1011, enc(6)); rst = 0;
        hold(4'b1011, enc(6), S);
        checks++;
        if (n_upd != u0 || digit2 !== 4'h0) begin
            errors++; $display("FAIL reset_abort got upd=%0d d2=%h exp upd=0 d2=0", n_upd - u0, digit2);
        end
        step(4'b1011, enc(6));
        checks++;
        if (update !== 1'b1 || digit2 !== 4'h6) begin
            errors++; $display("FAIL restart_cap got upd=%b d2=%h exp upd=1 d2=6", update, digit2);
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [6:0] s;
        int r;
        for (int seg_i = 0; seg_i < 150; seg_i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = ~(4'b0001 << $urandom_range(0, 3));
            else if (r == 7) a = 4'hF;
            else             a = 4'($urandom);
            r = $urandom_range(0, 9);
            if (r < 6)       s = enc($urandom_range(0, 15));
            else if (r == 6) s = 7'h7F;
            else             s = 7'($urandom);
            hold(a, s, $urandom_range(1, S + 4));
            checks++;
            if ({digit3, digit2, digit1, digit0, blank, invalid} !==
                {e_dig[3], e_dig[2], e_dig[1], e_dig[0], e_blank, e_inv}) begin
                errors++;
                $display("FAIL random%0d got d=%h b=%b i=%b exp d=%h b=%b i=%b", seg_i,
                         {digit3, digit2, digit1, digit0}, blank, invalid,
                         {e_dig[3], e_dig[2], e_dig[1], e_dig[0]}, e_blank, e_inv);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_glitch();
        test_blank_invalid();
        test_loopback();
        test_illegal_and_reset();
        test_random();
        checks++;
        if (skew != 0) begin errors++; $display("FAIL pulse_timing got %0d bad cycles exp 0", skew); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
